// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: turns each retiring write-back instruction into a numbered trace record,
// flags PCs that break the expected program flow, and queues records in a small FIFO for a consumer.
module commit_trace_buffer #(
    parameter int          DEPTH   = 4,
    parameter logic [31:0] PC_INIT = 32'h200
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_valid,
    input  logic [31:0]              wb_pc,
    input  logic [31:0]              wb_insn,
    input  logic                     wb_we,
    input  logic [4:0]               wb_dst,
    input  logic [31:0]              wb_r,
    output logic                     tr_valid,
    input  logic                     tr_ready,
    output logic [63:0]              tr_order,
    output logic [31:0]              tr_pc,
    output logic [31:0]              tr_insn,
    output logic [4:0]               tr_rd,
    output logic [31:0]              tr_rd_wdata,
    output logic                     tr_pc_err,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [63:0] order_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] insn_mem  [DEPTH];
    logic [4:0]  rd_mem    [DEPTH];
    logic [31:0] wdata_mem [DEPTH];
    logic        err_mem   [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   order_q, order_d;
    logic [31:0]   exp_pc_q, exp_pc_d;
    logic          exp_known_q, exp_known_d;
    logic          overflow_q, overflow_d;

    logic        pop;
    logic        push;
    logic [4:0]  rec_rd;
    logic [31:0] rec_wdata;
    logic [31:0] pc_aligned;
    logic        rec_err;
    logic [31:0] j_imm;

    assign pop        = (count_q != '0) && tr_ready;
    // A full FIFO can still accept a record when the head leaves in the same cycle.
    assign push       = wb_valid && ((count_q != FULL) || pop);
    assign rec_rd     = (wb_we && (wb_dst != 5'd0)) ? wb_dst : 5'd0;
    assign rec_wdata  = (wb_we && (wb_dst != 5'd0)) ? wb_r : 32'd0;
    assign pc_aligned = wb_pc & 32'hFFFF_FFFC;
    assign rec_err    = exp_known_q && (pc_aligned != exp_pc_q);
    assign j_imm      = {{12{wb_insn[31]}}, wb_insn[19:12], wb_insn[20], wb_insn[30:21], 1'b0};

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        order_d     = order_q;
        exp_pc_d    = exp_pc_q;
        exp_known_d = exp_known_q;
        overflow_d  = overflow_q;

        // Sequence number and flow prediction advance for every formed record, dropped or not.
        if (wb_valid) begin
            order_d = order_q + 64'd1;
            if (!push) begin
                overflow_d = 1'b1;
            end
            case (wb_insn[6:0])
                OPC_JAL: begin
                    exp_pc_d    = (wb_pc + j_imm) & 32'hFFFF_FFFC;
                    exp_known_d = 1'b1;
                end
                OPC_BRANCH, OPC_JALR: begin
                    exp_known_d = 1'b0;
                end
                default: begin
                    exp_pc_d    = pc_aligned + 32'd4;
                    exp_known_d = 1'b1;
                end
            endcase
        end

        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            order_q     <= 64'd0;
            exp_pc_q    <= PC_INIT;
            exp_known_q <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            order_q     <= order_d;
            exp_pc_q    <= exp_pc_d;
            exp_known_q <= exp_known_d;
            overflow_q  <= overflow_d;
        end
    end

    // Record storage is left unreset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            order_mem[tail_q] <= order_q;
            pc_mem[tail_q]    <= wb_pc;
            insn_mem[tail_q]  <= wb_insn;
            rd_mem[tail_q]    <= rec_rd;
            wdata_mem[tail_q] <= rec_wdata;
            err_mem[tail_q]   <= rec_err;
        end
    end

    assign tr_valid    = (count_q != '0);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign tr_order    = rst_n ? order_mem[head_q] : 64'd0;
    assign tr_pc       = rst_n ? pc_mem[head_q]    : 32'd0;
    assign tr_insn     = rst_n ? insn_mem[head_q]  : 32'd0;
    assign tr_rd       = rst_n ? rd_mem[head_q]    : 5'd0;
    assign tr_rd_wdata = rst_n ? wdata_mem[head_q] : 32'd0;
    assign tr_pc_err   = rst_n ? err_mem[head_q]   : 1'b0;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed vector table, hand-written FIFO corner
// sequences, and randomized traffic compared against a queue-based reference model.
module tb_commit_trace_buffer;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] PC_INIT = 32'h200;

    localparam logic [31:0] ADDI    = 32'h0050_0093;
    localparam logic [31:0] JAL16   = 32'h0100_006F;
    localparam logic [31:0] JALM8   = 32'hFF9F_F06F;
    localparam logic [31:0] BEQ     = 32'h0000_0063;
    localparam logic [31:0] JALR    = 32'h0000_8067;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_insn;
    logic        wb_we;
    logic [4:0]  wb_dst;
    logic [31:0] wb_r;
    logic        tr_valid;
    logic        tr_ready;
    logic [63:0] tr_order;
    logic [31:0] tr_pc;
    logic [31:0] tr_insn;
    logic [4:0]  tr_rd;
    logic [31:0] tr_rd_wdata;
    logic        tr_pc_err;
    logic        overflow;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    commit_trace_buffer #(.DEPTH(DEPTH), .PC_INIT(PC_INIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_insn(wb_insn),
        .wb_we(wb_we), .wb_dst(wb_dst), .wb_r(wb_r),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_order(tr_order),
        .tr_pc(tr_pc), .tr_insn(tr_insn), .tr_rd(tr_rd),
        .tr_rd_wdata(tr_rd_wdata), .tr_pc_err(tr_pc_err),
        .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of finished records plus the architectural prediction state.
    typedef struct {
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        err;
    } rec_t;

    rec_t        mq[$];
    logic [63:0] mOrder;
    logic [31:0] mExp;
    logic        mKnown;
    logic        mOvf;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        we;
        logic [4:0]  dst;
        logic [31:0] r;
        logic        ev;
        logic [63:0] eord;
        logic [31:0] epc;
        logic [4:0]  erd;
        logic [31:0] ewd;
        logic        eerr;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic modelClock(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                              input logic we, input logic [4:0] dst, input logic [31:0] r,
                              input logic ready, input logic rstn);
        rec_t        rec;
        logic [20:0] j;
        logic [31:0] jx;
        bit          canPop;
        bit          room;
        if (!rstn) begin
            mq.delete();
            mOrder = 64'd0;
            mExp   = PC_INIT;
            mKnown = 1'b1;
            mOvf   = 1'b0;
        end else begin
            canPop = (mq.size() > 0) && ready;
            room   = mq.size() < DEPTH;
            if (canPop) void'(mq.pop_front());
            if (v) begin
                rec.order = mOrder;
                mOrder    = mOrder + 64'd1;
                rec.pc    = pc;
                rec.insn  = insn;
                rec.rd    = (we && dst != 0) ? dst : 5'd0;
                rec.wdata = (we && dst != 0) ? r : 32'd0;
                rec.err   = mKnown && ((pc & ~32'd3) != mExp);
                j  = {insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
                jx = {{11{j[20]}}, j};
                if (insn[6:0] == 7'h6F) begin
                    mExp = (pc + jx) & ~32'd3;
                    mKnown = 1'b1;
                end else if (insn[6:0] == 7'h63 || insn[6:0] == 7'h67) begin
                    mKnown = 1'b0;
                end else begin
                    mExp = (pc & ~32'd3) + 32'd4;
                    mKnown = 1'b1;
                end
                if (room || canPop) mq.push_back(rec);
                else mOvf = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                                 input logic we, input logic [4:0] dst, input logic [31:0] r,
                                 input logic ready, input logic rstn);
        wb_valid = v;
        wb_pc    = pc;
        wb_insn  = insn;
        wb_we    = we;
        wb_dst   = dst;
        wb_r     = r;
        tr_ready = ready;
        rst_n    = rstn;
        modelClock(v, pc, insn, we, dst, r, ready, rstn);
        @(negedge clk);
    endtask

    task automatic checkOutput();
        chk("count", 64'(count), 64'(mq.size()));
        chk("tr_valid", 64'(tr_valid), 64'(mq.size() != 0));
        chk("overflow", 64'(overflow), 64'(mOvf));
        if (!rst_n) begin
            chk("rst order", tr_order, 64'd0);
            chk("rst pc", 64'(tr_pc), 64'd0);
            chk("rst rd", 64'(tr_rd), 64'd0);
            chk("rst err", 64'(tr_pc_err), 64'd0);
        end else if (mq.size() != 0) begin
            chk("head order", tr_order, mq[0].order);
            chk("head pc", 64'(tr_pc), 64'(mq[0].pc));
            chk("head insn", 64'(tr_insn), 64'(mq[0].insn));
            chk("head rd", 64'(tr_rd), 64'(mq[0].rd));
            chk("head wdata", 64'(tr_rd_wdata), 64'(mq[0].wdata));
            chk("head pc_err", 64'(tr_pc_err), 64'(mq[0].err));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] insn;
        logic [31:0] pc;
        int          sel;
        int          readyPct;

        tbl[0]  = '{1'b1, 32'h200,      ADDI,  1'b1, 5'd1,  32'h5,        1'b1, 64'd0,  32'h200,      5'd1,  32'h5,        1'b0};
        tbl[1]  = '{1'b1, 32'h208,      ADDI,  1'b1, 5'd1,  32'h7,        1'b1, 64'd1,  32'h208,      5'd1,  32'h7,        1'b1};
        tbl[2]  = '{1'b1, 32'h20C,      ADDI,  1'b1, 5'd2,  32'h9,        1'b1, 64'd2,  32'h20C,      5'd2,  32'h9,        1'b0};
        tbl[3]  = '{1'b1, 32'h300,      JAL16, 1'b1, 5'd0,  32'h304,      1'b1, 64'd3,  32'h300,      5'd0,  32'h0,        1'b1};
        tbl[4]  = '{1'b1, 32'h310,      ADDI,  1'b0, 5'd3,  32'hAA,       1'b1, 64'd4,  32'h310,      5'd0,  32'h0,        1'b0};
        tbl[5]  = '{1'b1, 32'h400,      BEQ,   1'b0, 5'd0,  32'h1234,     1'b1, 64'd5,  32'h400,      5'd0,  32'h0,        1'b1};
        tbl[6]  = '{1'b1, 32'h123C,     ADDI,  1'b1, 5'd5,  32'hBEEF,     1'b1, 64'd6,  32'h123C,     5'd5,  32'hBEEF,     1'b0};
        tbl[7]  = '{1'b1, 32'h1244,     ADDI,  1'b1, 5'd5,  32'h1,        1'b1, 64'd7,  32'h1244,     5'd5,  32'h1,        1'b1};
        tbl[8]  = '{1'b1, 32'h1248,     JALM8, 1'b1, 5'd0,  32'h124C,     1'b1, 64'd8,  32'h1248,     5'd0,  32'h0,        1'b0};
        tbl[9]  = '{1'b1, 32'h1240,     ADDI,  1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 64'd9,  32'h1240,     5'd31, 32'hFFFFFFFF, 1'b0};
        tbl[10] = '{1'b1, 32'h1244,     JALR,  1'b1, 5'd0,  32'h0,        1'b1, 64'd10, 32'h1244,     5'd0,  32'h0,        1'b0};
        tbl[11] = '{1'b1, 32'hDEAD0000, ADDI,  1'b0, 5'd1,  32'h2,        1'b1, 64'd11, 32'hDEAD0000, 5'd0,  32'h0,        1'b0};
        tbl[12] = '{1'b1, 32'hDEAD0006, ADDI,  1'b1, 5'd1,  32'h3,        1'b1, 64'd12, 32'hDEAD0006, 5'd1,  32'h3,        1'b0};
        tbl[13] = '{1'b1, 32'hFFFFFFFC, ADDI,  1'b1, 5'd1,  32'h4,        1'b1, 64'd13, 32'hFFFFFFFC, 5'd1,  32'h4,        1'b1};
        tbl[14] = '{1'b1, 32'h0,        ADDI,  1'b1, 5'd1,  32'h6,        1'b1, 64'd14, 32'h0,        5'd1,  32'h6,        1'b0};
        tbl[15] = '{1'b0, 32'h0,        ADDI,  1'b0, 5'd0,  32'h0,        1'b0, 64'd0,  32'h0,        5'd0,  32'h0,        1'b0};
        tbl[16] = '{1'b1, 32'h4,        ADDI,  1'b1, 5'd1,  32'h8,        1'b1, 64'd15, 32'h4,        5'd1,  32'h8,        1'b0};

        wb_valid = 1'b0; wb_pc = '0; wb_insn = '0; wb_we = 1'b0;
        wb_dst = '0; wb_r = '0; tr_ready = 1'b0; rst_n = 1'b0;

        // Reset state, with rst_n still low so the head data is forced to zero.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("reset count", 64'(count), 64'd0);
        chk("reset tr_valid", 64'(tr_valid), 64'd0);
        chk("reset overflow", 64'(overflow), 64'd0);
        chk("reset tr_order", tr_order, 64'd0);
        chk("reset tr_pc", 64'(tr_pc), 64'd0);
        chk("reset tr_rd_wdata", 64'(tr_rd_wdata), 64'd0);

        // Directed vectors with a ready consumer, so the head always shows the latest record.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i].v, tbl[i].pc, tbl[i].insn, tbl[i].we, tbl[i].dst, tbl[i].r, 1'b1, 1'b1);
            chk($sformatf("vec%0d valid", i), 64'(tr_valid), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d order", i), tr_order, tbl[i].eord);
                chk($sformatf("vec%0d pc", i), 64'(tr_pc), 64'(tbl[i].epc));
                chk($sformatf("vec%0d insn", i), 64'(tr_insn), 64'(tbl[i].insn));
                chk($sformatf("vec%0d rd", i), 64'(tr_rd), 64'(tbl[i].erd));
                chk($sformatf("vec%0d wdata", i), 64'(tr_rd_wdata), 64'(tbl[i].ewd));
                chk($sformatf("vec%0d pc_err", i), 64'(tr_pc_err), 64'(tbl[i].eerr));
            end
        end

        // Overflow: five retirements into a stalled four-entry FIFO.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 32'h200 + 32'(4 * i), ADDI, 1'b1, 5'd1, 32'(i), 1'b0, 1'b1);
        chk("ovf count", 64'(count), 64'd4);
        chk("ovf flag", 64'(overflow), 64'd1);
        chk("ovf head order", tr_order, 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain order%0d", i), tr_order, 64'(i));
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        end
        chk("drained count", 64'(count), 64'd0);
        chk("drained overflow sticky", 64'(overflow), 64'd1);
        applyStimulus(1'b1, 32'h214, ADDI, 1'b1, 5'd1, 32'h0, 1'b0, 1'b1);
        chk("post-drop order", tr_order, 64'd5);
        chk("post-drop pc_err", 64'(tr_pc_err), 64'd0);

        // Full FIFO with simultaneous pop and push.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'h200 + 32'(4 * i), ADDI, 1'b1, 5'd1, 32'(i), 1'b0, 1'b1);
        chk("full count", 64'(count), 64'd4);
        applyStimulus(1'b1, 32'h210, ADDI, 1'b1, 5'd1, 32'h4, 1'b1, 1'b1);
        chk("full swap count", 64'(count), 64'd4);
        chk("full swap overflow", 64'(overflow), 64'd0);
        chk("full swap order", tr_order, 64'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput();
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        end

        // Reset in the middle of traffic, with a record forming in the reset cycle.
        applyStimulus(1'b1, 32'h200, ADDI, 1'b1, 5'd1, 32'h1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h204, ADDI, 1'b1, 5'd1, 32'h2, 1'b0, 1'b1);
        rst_n = 1'b0; wb_valid = 1'b1; wb_pc = 32'h208;
        #1;
        chk("midrst valid before edge", 64'(tr_valid), 64'd1);
        chk("midrst tr_pc gated", 64'(tr_pc), 64'd0);
        chk("midrst tr_order gated", tr_order, 64'd0);
        applyStimulus(1'b1, 32'h208, ADDI, 1'b1, 5'd1, 32'h3, 1'b0, 1'b0);
        chk("midrst count", 64'(count), 64'd0);
        chk("midrst valid", 64'(tr_valid), 64'd0);
        applyStimulus(1'b1, 32'h200, ADDI, 1'b1, 5'd1, 32'h4, 1'b0, 1'b1);
        chk("midrst new order", tr_order, 64'd0);
        chk("midrst new pc_err", 64'(tr_pc_err), 64'd0);
        chk("midrst new count", 64'(count), 64'd1);

        // Randomized traffic against the reference model.
        readyPct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) readyPct = (c / 500 % 3 == 0) ? 20 : ((c / 500 % 3 == 1) ? 90 : 50);
            checkOutput();
            sel = $urandom_range(0, 9);
            insn = $urandom;
            case (sel)
                0, 1:    insn[6:0] = 7'h6F;
                2:       insn[6:0] = 7'h63;
                3:       insn[6:0] = 7'h67;
                4:       insn = insn;
                default: insn[6:0] = 7'h13;
            endcase
            pc = ($urandom_range(0, 3) != 0) ? (mExp | 32'($urandom_range(0, 3))) : $urandom;
            applyStimulus($urandom_range(0, 3) != 0, pc, insn, 1'($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                          $urandom, $urandom_range(0, 99) < readyPct,
                          $urandom_range(0, 199) != 0);
        end
        checkOutput();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 4, trace FIFO entries; power of two, at least 2.
REQ-002 Parameter PC_INIT, default 32'h200, first PC the block expects to retire after reset.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 wb_valid  input  1  write-back stage holds a retiring, non-bubble instruction this cycle.
REQ-006 wb_pc  input  32  PC of the retiring instruction.
REQ-007 wb_insn  input  32  instruction word of the retiring instruction.
REQ-008 wb_we  input  1  register-file write enable from write-back.
REQ-009 wb_dst  input  5  destination register index from write-back.
REQ-010 wb_r  input  32  write-back data.
REQ-011 tr_valid  output  1  trace record available at the FIFO head.
REQ-012 tr_ready  input  1  consumer accepts the head record.
REQ-013 tr_order  output  64  retirement sequence number of the head record.
REQ-014 tr_pc, tr_insn  output  32 each  PC and instruction of the head record.
REQ-015 tr_rd  output  5  destination index of the head record; 0 when no write occurs.
REQ-016 tr_rd_wdata  output  32  write data of the head record; 0 when tr_rd is 0.
REQ-017 tr_pc_err  output  1  head record's PC differs from the expected next PC.
REQ-018 overflow  output  1  sticky flag: a retirement was dropped because the FIFO was full.
REQ-019 count  output  $clog2(DEPTH)+1  current number of FIFO entries.

Function
REQ-020 Each cycle with wb_valid=1 forms exactly one record; cycles with wb_valid=0 form none.
REQ-021 Record rd is wb_dst when wb_we=1 and wb_dst!=0; otherwise rd=0 and wdata=0, whatever the value of wb_r.
REQ-022 The 64-bit order counter resets to 0; each formed record takes the current value, and the counter then increments, including for records that are dropped; it wraps modulo 2^64.
REQ-023 The expected-PC register resets to PC_INIT and has an exp_known flag, reset value 1.
REQ-024 When a record forms:
  - pc_err = exp_known && (wb_pc & 32'hFFFFFFFC) != expected PC.
  - The expected PC and exp_known then update from the record's opcode, wb_insn[6:0].
REQ-025 Opcode 1101111 (jal): expected = (wb_pc + sext J-imm) & 32'hFFFFFFFC; exp_known=1.
REQ-026 Opcode 1100011 (branch) or 1100111 (jalr): exp_known=0, so the next record is not PC-checked.
REQ-027 Any other opcode: expected = (wb_pc & 32'hFFFFFFFC) + 4, modulo 2^32; exp_known=1.
REQ-028 The FIFO is DEPTH entries, written at a tail pointer and read at a head pointer; pointers wrap modulo DEPTH.
REQ-029 A record is pushed when count<DEPTH, or when count==DEPTH and tr_valid&&tr_ready in the same cycle.
REQ-030 Otherwise the record is dropped: overflow sets to 1 and holds until reset.
REQ-031 A pop occurs when tr_valid&&tr_ready; all tr_* outputs show the head entry directly from storage.
REQ-032 tr_valid = (count!=0); there is no bypass, so a record pushed in cycle N first appears at cycle N+1.
REQ-033 Simultaneous push and pop at a nonzero count leaves count unchanged; with count==0 only the push takes effect.
REQ-034 tr_* data stays stable while tr_valid=1 and tr_ready=0.
REQ-035 tr_ready while tr_valid=0 has no effect.

Reset
REQ-036 With rst_n=0 at a clock edge:
  - count=0, head=tail=0, tr_valid=0, overflow=0.
  - Order counter=0; expected PC=PC_INIT; exp_known=1.
REQ-037 While rst_n=0, tr_order, tr_pc, tr_insn, tr_rd, tr_rd_wdata and tr_pc_err drive 0.
REQ-038 Reset mid-operation discards all queued records and any record formed in that same cycle.
REQ-039 FIFO storage contents need no reset.

Verification
REQ-040 Retire addi x1 (13'h... insn 32'h00500093) at pc 0x200, wb_r=5, tr_ready=1 -> next cycle tr_valid=1, order=0, pc=0x200, rd=1, wdata=5, pc_err=0.
REQ-041 Retire non-branches at 0x200 then 0x208 -> second record has pc_err=1; a following retire at 0x20C has pc_err=0.
REQ-042 Retire jal x0,+16 at 0x300, then 0x310 -> rd=0, wdata=0 despite wb_r=0x304; second record pc_err=0.
REQ-043 Retire beq at 0x400, then a record at 0x123C -> pc_err=0; the next retire at 0x1244 -> pc_err=1.
REQ-044 DEPTH=4, tr_ready=0, retire 5 records -> count=4, overflow=1, head order=0; drain -> orders 0,1,2,3, and the next new record has order 5.
REQ-045 Count=4 with tr_ready=1 and wb_valid=1 together -> push accepted, count stays 4, overflow stays 0.
